// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the serialiser state
// encoding, frame geometry constants and the reset-time default divisor.
// The PARITY state is always part of the encoding, so state values stay the
// same whether or not the UART_TX_PARITY_EN build macro is defined.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DIV_W      = 16;

    // 100 MHz system clock / 115200 baud.
    localparam logic [UART_DIV_W-1:0] UART_DEFAULT_DIV = 16'd868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // A frame is on the line in every state except IDLE.
    function automatic logic state_is_busy(input tx_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous circular-buffer FIFO for bytes waiting to be transmitted.
// Full/empty are judged from the count at the start of the cycle: a push
// while full is dropped even if a pop happens in the same cycle.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (flushes the FIFO)
//   push       write request
//   push_data  data to write
//   pop        read request (ignored when empty)
//   head       entry at the read pointer
//   full       registered, count == DEPTH
//   empty      registered, count == 0
//   count      current number of entries
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_r;
    logic             empty_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W:0]   count_next_s;

    // Accept/perform decisions from the count held at the start of the cycle.
    always_comb begin
        push_ok_s = push && (count_r != CNT_DEPTH);
        pop_ok_s  = pop  && (count_r != CNT_ZERO);
    end

    // Next occupancy; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_DEPTH);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Storage array; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/uart_tx_unit.sv
// ---------------------------------------------------------------------------
// uart_tx_unit
// UART transmitter fed by LSU stores to the TX register. Bytes are queued in
// a small FIFO and sent as start + DATA_W data bits (LSB first) + stop, each
// bit lasting baud_div clock cycles. The divisor is captured at the start of
// every frame, so a change takes effect on the next frame.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset; aborts any frame in flight
//   wr_en     one-cycle write strobe from the LSU
//   wr_data   byte to transmit
//   baud_div  clock cycles per bit (0 behaves as 1)
//   tx        serial output, registered, idles high
//   busy      a frame is on the line
//   Ff        FIFO full
//   Fe        FIFO empty
//   done_t    one-cycle pulse following the last stop-bit cycle
// ---------------------------------------------------------------------------
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = UART_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              tx,
    output logic              busy,
    output logic              Ff,
    output logic              Fe,
    output logic              done_t
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    // A zero divisor would never reach bit_end; run it at one cycle per bit.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        if (d == DIV_ZERO) begin
            return DIV_ONE;
        end else begin
            return d;
        end
    endfunction

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    tx_state_t         state_r;
    tx_state_t         state_next_s;

    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;
    logic [IDX_W-1:0]  idx_r;
`ifdef UART_TX_PARITY_EN
    logic              par_r;
`endif

    logic              bit_end_s;
    logic              pop_s;
    logic              have_data_s;

    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    logic              tx_d_s;
    logic              busy_d_s;
    logic              done_d_s;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign have_data_s = (fifo_count_s != CNT_ZERO);
    assign bit_end_s   = (cnt_r == (div_r - DIV_ONE));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and FIFO pop requests.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (have_data_s) begin
                    pop_s        = 1'b1;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (idx_r == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    // Chain straight into the next frame when data is waiting.
                    if (have_data_s) begin
                        pop_s        = 1'b1;
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Shift register contents for the next cycle.
    always_comb begin
        if (pop_s) begin
            shift_next_s = fifo_head_s;
        end else if ((state_r == DATA) && bit_end_s) begin
            shift_next_s = shift_r >> 1;
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Baud counter, captured divisor, shift register and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= DIV_ZERO;
            div_r   <= DIV_ONE;
            shift_r <= '0;
            idx_r   <= IDX_ZERO;
`ifdef UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            shift_r <= shift_next_s;
            if (pop_s) begin
                cnt_r <= DIV_ZERO;
                div_r <= eff_div(baud_div);
                idx_r <= IDX_ZERO;
`ifdef UART_TX_PARITY_EN
                par_r <= even_parity(fifo_head_s);
`endif
            end else if (state_r == IDLE) begin
                cnt_r <= DIV_ZERO;
            end else if (bit_end_s) begin
                cnt_r <= DIV_ZERO;
                if (state_r == DATA) begin
                    idx_r <= idx_r + IDX_ONE;
                end else begin
                    idx_r <= idx_r;
                end
            end else begin
                cnt_r <= cnt_r + DIV_ONE;
            end
        end
    end

    // Output values for the state being entered, so tx changes with the state.
    always_comb begin
        busy_d_s = state_is_busy(state_next_s);
        done_d_s = (state_r == STOP) && bit_end_s;
        case (state_next_s)
            IDLE:    tx_d_s = 1'b1;
            START:   tx_d_s = 1'b0;
            DATA:    tx_d_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d_s = par_r;
`endif
            STOP:    tx_d_s = 1'b1;
            default: tx_d_s = 1'b1;
        endcase
    end

    // Output registers: no combinational path from any input to tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_d_s;
            busy_r <= busy_d_s;
            done_r <= done_d_s;
        end
    end

    assign tx     = tx_r;
    assign busy   = busy_r;
    assign done_t = done_r;
    assign Ff     = fifo_full_s;
    assign Fe     = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_unit.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_unit
// Scoreboard bench for uart_tx_unit. Stimulus pushes the expected frame of
// every byte it writes into exp_q; a monitor detects each start bit on tx,
// pops the next expectation and checks every bit for its exact duration,
// busy throughout, and the done_t pulse in the cycle after the stop bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [15:0] baud_div = 16'd4;
    logic        tx, busy, Ff, Fe, done_t;

    int n_checks = 0;
    int n_fail = 0;
    int busy_cycles = 0;
    bit mon_active = 1'b0;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          div;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_unit dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .baud_div (baud_div),
        .tx       (tx),
        .busy     (busy),
        .Ff       (Ff),
        .Fe       (Fe),
        .done_t   (done_t)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected line levels in time order for byte d sent at div cycles/bit.
    function automatic exp_t mk(input logic [7:0] d, input int div);
        exp_t e;
        e.bits = 11'b0;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
        e.bits[9]  = ^d;
        e.bits[10] = 1'b1;
        e.nbits    = 11;
`else
        e.bits[9]  = 1'b1;
        e.nbits    = 10;
`endif
        e.div = div;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || mon_active) && i < budget) begin
            tick(1);
            i++;
        end
        check("drain_in_time", {31'd0, (exp_q.size() == 0 && !mon_active)}, 32'd1);
    endtask

    // Monitor: frame decoder and scoreboard comparison.
    initial begin : monitor
        exp_t        e;
        logic [10:0] got;
        logic        bad_t;
        logic        aborted;
        bit          skip;
        skip = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (tx === 1'b0 && rst === 1'b0) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {31'd0, tx}, 32'd1);
                    while (tx === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    got = 11'b0;
                    bad_t = 1'b0;
                    aborted = 1'b0;
                    for (int b = 0; b < e.nbits && !aborted; b++) begin
                        for (int c = 0; c < e.div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst === 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) got[b] = tx;
                                else if (tx !== got[b]) bad_t = 1'b1;
                                if (busy !== 1'b1) bad_t = 1'b1;
                                // cycle 0 may carry the previous frame's done pulse
                                if ((b != 0 || c != 0) && done_t !== 1'b0) bad_t = 1'b1;
                            end
                        end
                    end
                    if (!aborted) begin
                        check("frame_bits", {21'd0, got}, {21'd0, e.bits});
                        check("frame_timing", {31'd0, bad_t}, 32'd0);
                        @(negedge clk);
                        check("done_t_pulse", {31'd0, done_t}, 32'd1);
                        skip = 1'b1;
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int low_cnt;

        // Reset held three cycles.
        tick(3);
        rst = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_Fe", {31'd0, Fe}, 32'd1);
        check("rst_Ff", {31'd0, Ff}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_t", {31'd0, done_t}, 32'd0);
        tick(2);

        // Single byte A5 at 4 cycles/bit; tx falls two cycles after wr_en.
        baud_div = 16'd4;
        busy_cycles = 0;
        exp_q.push_back(mk(8'hA5, 4));
        write_byte(8'hA5);
        check("lat_tx_still_high", {31'd0, tx}, 32'd1);
        tick(1);
        check("lat_tx_fall", {31'd0, tx}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        drain(200);
        check("single_busy_cycles", busy_cycles, 32'd40);
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_Fe", {31'd0, Fe}, 32'd1);
        tick(3);

        // Back-to-back at 2 cycles/bit. Byte 01 is popped as 02 arrives, so
        // 02..05 fill the FIFO and 06 is dropped.
        baud_div = 16'd2;
        busy_cycles = 0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(mk(8'(i), 2));
        for (int i = 1; i <= 6; i++) write_byte(8'(i));
        check("full_after_fill", {31'd0, Ff}, 32'd1);
        check("not_empty_after_fill", {31'd0, Fe}, 32'd0);
        tick(15);
        check("full_before_pop", {31'd0, Ff}, 32'd1);
        tick(1);
        check("full_drops_on_pop", {31'd0, Ff}, 32'd0);
        drain(400);
        check("b2b_busy_cycles", busy_cycles, 32'd100);
        check("b2b_Fe", {31'd0, Fe}, 32'd1);
        check("b2b_tx_idle", {31'd0, tx}, 32'd1);
        tick(3);

        // Divisor change mid-frame: FF keeps 3 cycles/bit, 00 uses 5.
        baud_div = 16'd3;
        busy_cycles = 0;
        exp_q.push_back(mk(8'hFF, 3));
        exp_q.push_back(mk(8'h00, 5));
        write_byte(8'hFF);
        write_byte(8'h00);
        tick(5);
        baud_div = 16'd5;
        drain(400);
        check("divchg_busy_cycles", busy_cycles, 32'd80);
        tick(3);

        // A zero divisor runs at one cycle per bit.
        baud_div = 16'd0;
        busy_cycles = 0;
        exp_q.push_back(mk(8'h5A, 1));
        write_byte(8'h5A);
        drain(100);
        check("div0_busy_cycles", busy_cycles, 32'd10);
        tick(3);

        // Reset during data bit 4 of 3C with two more bytes queued.
        baud_div = 16'd8;
        exp_q.push_back(mk(8'h3C, 8));
        write_byte(8'h3C);
        write_byte(8'h11);
        write_byte(8'h22);
        tick(40);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_Fe", {31'd0, Fe}, 32'd1);
        check("midrst_Ff", {31'd0, Ff}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        low_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (tx !== 1'b1) low_cnt++;
        end
        check("no_frame_after_rst", low_cnt, 32'd0);
        check("midrst_queue_empty", exp_q.size(), 32'd0);

`ifdef UART_TX_PARITY_EN
        // 07 has three ones: parity bit 1, 22-cycle frame.
        baud_div = 16'd2;
        busy_cycles = 0;
        exp_q.push_back(mk(8'h07, 2));
        write_byte(8'h07);
        drain(200);
        check("parity_busy_cycles", busy_cycles, 32'd22);
        tick(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
